dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter placed in front of the single-port `data_mem` word memory, letting the core load/store unit (port 0) and a debug/DMA master (port 1) share it. Each cycle it grants at most one requester, drives the memory's address, write data and byte write enables from the winner, and returns a one-cycle-delayed response to the winner. Arbitration is stateful (owner register plus burst counter), so a steady stream from one master cannot starve the other.

## Interface
- `BURST_MAX`, default 4: maximum consecutive grants to the current owner while the other port is also requesting (sticky mode only); legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  request valid, held until granted.
- `p0_addr`, `p1_addr`  in  32  byte address; the memory uses bits [11:2].
- `p0_wdata`, `p1_wdata`  in  32  write data.
- `p0_we`, `p1_we`  in  4  byte write enables; 0 means read.
- `p0_gnt`, `p1_gnt`  out  1  combinational grant; a request is accepted in the cycle where both req and gnt are high.
- `p0_rvalid`, `p1_rvalid`  out  1  registered response strobe, one cycle after acceptance.
- `p0_rdata`, `p1_rdata`  out  32  response data; meaningful only while the matching rvalid is high.
- `mem_addr`  out  32  to the memory address input.
- `mem_din`  out  32  to the memory write-data input.
- `mem_we`  out  4  to the memory byte write enables.
- `mem_dout`  in  32  from the memory read-data output.

## Operation
- State:
  - `owner` (1 bit): last granted port.
  - `burst_cnt` (4 bits): consecutive grants to `owner`.
  - `resp_valid` / `resp_port`: response pipeline register.
- Grant decision (combinational, from the requests and state):
  - No request: no grant.
  - Exactly one request: grant that port.
  - Both requesting, sticky mode: grant `owner` if `burst_cnt < BURST_MAX`, otherwise grant the other port.
  - Both requesting, alternate mode: grant `!owner`.
- Memory drive:
  - On a grant, `mem_addr`, `mem_din` and `mem_we` come from the granted port.
  - With no grant, `mem_addr = p0_addr`, `mem_din = p0_wdata`, `mem_we = 0`.
- State update on a grant to port g:
  - If g differs from `owner`: `owner <= g`, `burst_cnt <= 1`.
  - Otherwise `burst_cnt` increments, saturating at 15.
  - A cycle with no grant leaves `owner` and `burst_cnt` unchanged.
- Response:
  - `resp_valid <= (any grant)` and `resp_port <= g`.
  - `pN_rvalid = resp_valid && resp_port == N`.
  - `p0_rdata = p1_rdata = mem_dout`.
- Writes also produce an rvalid (acknowledge). The rdata returned with a write is the pre-write word (read-before-write behaviour of the memory).
- Only the granted port's rdata is qualified. The other port must ignore rdata.

## Timing
- Grant has zero latency: `gnt` settles in the same cycle as `req`.
- The memory samples at edge T+1 for a request accepted in cycle T. rvalid and rdata are valid in cycle T+1 and last one cycle.
- Throughput is one access per cycle, back-to-back, from either port.
- A new request from the same or the other port may be accepted in the same cycle as the previous response; there is no turnaround bubble.
- A read of an address written in the previous cycle returns the new data.
- Reset values: `owner = 1` (port 0 wins the first tie), `burst_cnt = 0`, `resp_valid = 0`, all rvalid = 0, all gnt determined only by req.
- `rst` asserted mid-access: the pending rvalid clears immediately and the response is lost. A write already sampled by the memory at an earlier edge stands.

## Configuration
- `DMEM_ARB_STICKY_EN` defined: sticky arbitration with a `BURST_MAX` limit, as above.
- Not defined: strict alternation on every contended cycle. `BURST_MAX` and `burst_cnt` are unused, and `burst_cnt` may be optimised out.

## Test plan
- Reset, then p0 reads 0x10 alone: `p0_gnt = 1` the same cycle; `p0_rvalid = 1` next cycle with the word at index 4; p1 signals stay 0.
- p1 writes `0xAABBCCDD` with we=`0011` to 0x20, then p0 reads 0x20: p0 receives `0x????CCDD`, with the upper bytes unchanged from before the write.
- Both request continuously from reset, sticky, `BURST_MAX = 4`: grant sequence is 0,0,0,0,1,1,1,1,0 and so on. Without the macro: 0,1,0,1 and so on.
- p0 writes `0x12345678` to 0x40 in cycle T, p1 reads 0x40 in cycle T+1: p1 rdata = `0x12345678` in T+2, with p0 rvalid in T+1 and p1 rvalid in T+2.
- Assert `rst` in the cycle after p1 is accepted: `p1_rvalid` drops asynchronously; after release, the first contended grant goes to p0.
- Write via p0 returns the old word: location 0x08 preloaded with `0xDEADBEEF`, p0 writes `0x0`, rdata = `0xDEADBEEF`; a subsequent read returns 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one single-port data memory between the load/store unit (p0) and a debug/DMA master (p1).
// Define DMEM_ARB_STICKY_EN for sticky bursts limited by BURST_MAX; otherwise contended cycles strictly alternate.
module dmem_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_we,
    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_we,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_dout
);

    logic owner;
    logic tie_port;
    logic any_gnt;
    logic gnt_port;
    logic resp_valid;
    logic resp_port;

    // An out-of-range BURST_MAX shows up as this named block in the elaborated hierarchy.
    if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_burst_max_out_of_range
    end

`ifdef DMEM_ARB_STICKY_EN
    localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX);

    logic [3:0] burst_cnt;

    // burst_cnt == 0 means no burst has started yet, so the first tie goes to !owner (port 0 after reset).
    always_comb begin
        tie_port = ~owner;
        if (burst_cnt != 4'd0 && burst_cnt < BURST_LIMIT) begin
            tie_port = owner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= 4'd0;
        end else if (any_gnt) begin
            if (gnt_port != owner) begin
                burst_cnt <= 4'd1;
            end else if (burst_cnt != 4'd15) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end
    end
`else
    always_comb begin
        tie_port = ~owner;
    end
`endif

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (p0_req && p1_req) begin
            p0_gnt = ~tie_port;
            p1_gnt = tie_port;
        end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
        end
    end

    assign any_gnt  = p0_gnt | p1_gnt;
    assign gnt_port = p1_gnt;

    // Idle cycles still present p0's address so the memory port never floats, but never write.
    always_comb begin
        mem_addr = p0_addr;
        mem_din  = p0_wdata;
        mem_we   = 4'b0000;
        if (p1_gnt) begin
            mem_addr = p1_addr;
            mem_din  = p1_wdata;
            mem_we   = p1_we;
        end else if (p0_gnt) begin
            mem_we   = p0_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= 1'b1;
        end else if (any_gnt) begin
            owner <= gnt_port;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_port  <= 1'b0;
        end else begin
            resp_valid <= any_gnt;
            resp_port  <= gnt_port;
        end
    end

    assign p0_rvalid = resp_valid & ~resp_port;
    assign p1_rvalid = resp_valid & resp_port;
    assign p0_rdata  = mem_dout;
    assign p1_rdata  = mem_dout;

endmodule
